// File: rtl/mem_access_ctrl_if.sv
// CPU request/response and memory bus bundle for mem_access_ctrl.
// slave = controller side, master = CPU/memory side.
interface mem_access_ctrl_if #(
    parameter int WL = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [WL-1:0] cpu_addr;
    logic [WL-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          cpu_done;
    logic [WL-1:0] cpu_rdata;
    logic          cpu_err;
    logic [WL-1:0] mra;
    logic [WL-1:0] mwd;
    logic          mwe;
    logic [WL-1:0] mrd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mrd,
        output cpu_ready, cpu_done, cpu_rdata, cpu_err,
        output mra, mwd, mwe
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mrd,
        input  cpu_ready, cpu_done, cpu_rdata, cpu_err,
        input  mra, mwd, mwe
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-port memory access sequencer: SETUP, optional WAIT, ACCESS, DONE.
// Optional address range check enabled by MEM_BOUNDS_CHECK_EN.
module mem_access_ctrl #(
    parameter int WL       = 16,
    parameter int WD       = 256,
    parameter int WAIT_CYC = 0
) (
    input logic           clk,
    input logic           rst,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    if (WAIT_CYC > 15 || WAIT_CYC < 0) begin : g_bad_wait
        $error("mem_access_ctrl: WAIT_CYC must be 0..15");
    end
    if (WD < 1) begin : g_bad_wd
        $error("mem_access_ctrl: WD must be positive");
    end

    state_t        state;
    state_t        nxt;
    logic          ready;
    logic          accept;
    logic          bad;
    logic          we_q;
    logic [3:0]    cnt;
    logic [WL-1:0] mra_q;
    logic [WL-1:0] mwd_q;
    logic          mwe_q;
    logic          done_q;
    logic [WL-1:0] rdata_q;

    // Ready is forced low while reset is held, even though state is IDLE.
    assign ready  = (state == S_IDLE) & rst;
    assign accept = bus.cpu_req & ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (1'b1)
            (state == S_IDLE): begin
                if (accept) nxt = S_SETUP;
            end
            (state == S_SETUP): begin
                if (bad)               nxt = S_DONE;
                else if (WAIT_CYC > 0) nxt = S_WAIT;
                else                   nxt = S_ACCESS;
            end
            (state == S_WAIT): begin
                if (cnt <= 4'd1) nxt = S_ACCESS;
            end
            (state == S_ACCESS): nxt = S_DONE;
            (state == S_DONE):   nxt = S_IDLE;
            default:             nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            cnt     <= 4'd0;
            mra_q   <= '0;
            mwd_q   <= '0;
            mwe_q   <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q  <= bus.cpu_we;
                mra_q <= bus.cpu_addr;
                mwd_q <= bus.cpu_wdata;
            end
            if (state == S_SETUP)     cnt <= 4'(WAIT_CYC);
            else if (state == S_WAIT) cnt <= cnt - 4'd1;
            mwe_q  <= (nxt == S_ACCESS) & we_q;
            done_q <= (nxt == S_DONE);
            if (state == S_ACCESS && !we_q) rdata_q <= bus.mrd;
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    logic err_q;
    logic err_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
            err_o <= 1'b0;
        end else begin
            if (accept)
                err_q <= ({1'b0, bus.cpu_addr} >= (WL+1)'(WD));
            err_o <= (nxt == S_DONE) & err_q;
        end
    end

    assign bad         = err_q;
    assign bus.cpu_err = err_o;
`else
    assign bad         = 1'b0;
    assign bus.cpu_err = 1'b0;
`endif

    assign bus.cpu_ready = ready;
    assign bus.cpu_done  = done_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.mra       = mra_q;
    assign bus.mwd       = mwd_q;
    assign bus.mwe       = mwe_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: WAIT_CYC=0 and WAIT_CYC=3 instances
// sharing clock and reset, each with its own memory model.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.WL(16)) if0 ();
    mem_access_ctrl_if #(.WL(16)) if3 ();

    mem_access_ctrl #(.WL(16), .WD(256), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    mem_access_ctrl #(.WL(16), .WD(256), .WAIT_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic        req_d  [2];
    logic        we_d   [2];
    logic [15:0] addr_d [2];
    logic [15:0] wd_d   [2];

    assign if0.cpu_req   = req_d[0];
    assign if0.cpu_we    = we_d[0];
    assign if0.cpu_addr  = addr_d[0];
    assign if0.cpu_wdata = wd_d[0];
    assign if3.cpu_req   = req_d[1];
    assign if3.cpu_we    = we_d[1];
    assign if3.cpu_addr  = addr_d[1];
    assign if3.cpu_wdata = wd_d[1];

    logic [15:0] mem0 [256];
    logic [15:0] mem3 [256];
    logic        minit = 1'b0;

    // Memories take a known pattern A5xx on the first edge, then act as RAM.
    always @(posedge clk) begin
        if (!minit) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 16'hA500 | 16'(i);
                mem3[i] <= 16'hA500 | 16'(i);
            end
            minit <= 1'b1;
        end else begin
            if (if0.mwe && if0.mra < 16'd256) mem0[if0.mra[7:0]] <= if0.mwd;
            if (if3.mwe && if3.mra < 16'd256) mem3[if3.mra[7:0]] <= if3.mwd;
        end
    end

    assign if0.mrd = (if0.mra < 16'd256) ? mem0[if0.mra[7:0]] : 16'hDEAD;
    assign if3.mrd = (if3.mra < 16'd256) ? mem3[if3.mra[7:0]] : 16'hDEAD;

    logic        o_rdy  [2];
    logic        o_done [2];
    logic        o_err  [2];
    logic        o_mwe  [2];
    logic [15:0] o_mra  [2];
    logic [15:0] o_mwd  [2];
    logic [15:0] o_rd   [2];

    assign o_rdy[0]  = if0.cpu_ready;
    assign o_done[0] = if0.cpu_done;
    assign o_err[0]  = if0.cpu_err;
    assign o_mwe[0]  = if0.mwe;
    assign o_mra[0]  = if0.mra;
    assign o_mwd[0]  = if0.mwd;
    assign o_rd[0]   = if0.cpu_rdata;
    assign o_rdy[1]  = if3.cpu_ready;
    assign o_done[1] = if3.cpu_done;
    assign o_err[1]  = if3.cpu_err;
    assign o_mwe[1]  = if3.mwe;
    assign o_mra[1]  = if3.mra;
    assign o_mwd[1]  = if3.mwd;
    assign o_rd[1]   = if3.cpu_rdata;

    int acc0   = 0;
    int mwes3  = 0;
    int dones3 = 0;

    always @(posedge clk) begin
        if (if0.cpu_req && if0.cpu_ready) acc0++;
        if (if3.mwe) mwes3++;
        if (if3.cpu_done) dones3++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; lat = cycles from accept edge to the done cycle.
    task automatic txn(input int s, input logic we, input logic [15:0] a,
                       input logic [15:0] d, output int lat, output int nmwe,
                       output logic err, output logic [15:0] rd,
                       output logic stable);
        bit fin;
        lat    = 0;
        nmwe   = 0;
        err    = 1'b0;
        rd     = 16'h0;
        stable = 1'b1;
        fin    = 1'b0;
        for (int k = 0; k < 20 && o_rdy[s] !== 1'b1; k++) tick();
        req_d[s]  = 1'b1;
        we_d[s]   = we;
        addr_d[s] = a;
        wd_d[s]   = d;
        tick();
        req_d[s] = 1'b0;
        for (int k = 1; k <= 20 && !fin; k++) begin
            if (o_mwe[s] === 1'b1) nmwe++;
            if (o_mra[s] !== a || (we && o_mwd[s] !== d)) stable = 1'b0;
            if (o_done[s] === 1'b1) begin
                lat = k;
                err = o_err[s];
                rd  = o_rd[s];
                fin = 1'b1;
            end else begin
                tick();
            end
        end
        tick();
    endtask

    int          lat;
    int          nmwe;
    logic        err;
    logic [15:0] rd;
    logic        stable;
    int          a0;
    int          m3;
    int          d3;

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_d[i]  = 1'b1;
            we_d[i]   = 1'b1;
            addr_d[i] = 16'h0033;
            wd_d[i]   = 16'h4444;
        end
        repeat (3) tick();

        check("rst_ready0", 32'(if0.cpu_ready), 32'd0);
        check("rst_ready3", 32'(if3.cpu_ready), 32'd0);
        check("rst_mra", 32'(if0.mra), 32'd0);
        check("rst_mwd", 32'(if0.mwd), 32'd0);
        check("rst_mwe", 32'(if0.mwe), 32'd0);
        check("rst_rdata", 32'(if0.cpu_rdata), 32'd0);
        check("rst_done", 32'(if0.cpu_done), 32'd0);
        check("rst_err", 32'(if0.cpu_err), 32'd0);

        req_d[0] = 1'b0;
        req_d[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rel_ready0", 32'(if0.cpu_ready), 32'd1);
        check("rel_ready3", 32'(if3.cpu_ready), 32'd1);
        check("rst_no_accept", 32'(acc0), 32'd0);

        txn(0, 1'b1, 16'h0005, 16'h1234, lat, nmwe, err, rd, stable);
        check("wr5_latency", 32'(lat), 32'd3);
        check("wr5_mwe_cycles", 32'(nmwe), 32'd1);
        check("wr5_bus_stable", 32'(stable), 32'd1);
        check("wr5_mem", 32'(mem0[5]), 32'h1234);
        check("wr5_rdata_kept", 32'(rd), 32'h0000);

        txn(0, 1'b0, 16'h0005, 16'h0000, lat, nmwe, err, rd, stable);
        check("rd5_latency", 32'(lat), 32'd3);
        check("rd5_data", 32'(rd), 32'h1234);
        check("rd5_no_mwe", 32'(nmwe), 32'd0);
        check("done_pulse_one", 32'(if0.cpu_done), 32'd0);

        txn(1, 1'b0, 16'h0010, 16'h0000, lat, nmwe, err, rd, stable);
        check("w3_rd_latency", 32'(lat), 32'd6);
        check("w3_rd_mra_stable", 32'(stable), 32'd1);
        check("w3_rd_data", 32'(rd), 32'hA510);

        a0 = acc0;
        req_d[0]  = 1'b1;
        we_d[0]   = 1'b1;
        addr_d[0] = 16'h0007;
        wd_d[0]   = 16'hBEEF;
        tick();
        we_d[0] = 1'b0;
        wd_d[0] = 16'h0000;
        tick();
        check("b2b_mwe", 32'(if0.mwe), 32'd1);
        tick();
        check("b2b_wr_done", 32'(if0.cpu_done), 32'd1);
        check("b2b_wr_rdata_kept", 32'(if0.cpu_rdata), 32'h1234);
        tick();
        check("b2b_idle_ready", 32'(if0.cpu_ready), 32'd1);
        tick();
        req_d[0] = 1'b0;
        check("b2b_accepts", 32'(acc0 - a0), 32'd2);
        tick();
        tick();
        check("b2b_rd_done", 32'(if0.cpu_done), 32'd1);
        check("b2b_rd_data", 32'(if0.cpu_rdata), 32'hBEEF);
        tick();

        txn(0, 1'b1, 16'h0100, 16'h7777, lat, nmwe, err, rd, stable);
`ifdef MEM_BOUNDS_CHECK_EN
        check("oob_latency", 32'(lat), 32'd2);
        check("oob_err", 32'(err), 32'd1);
        check("oob_no_mwe", 32'(nmwe), 32'd0);
`else
        check("oob_latency", 32'(lat), 32'd3);
        check("oob_err", 32'(err), 32'd0);
        check("oob_mwe", 32'(nmwe), 32'd1);
`endif
        check("oob_rdata_kept", 32'(rd), 32'hBEEF);

        m3 = mwes3;
        d3 = dones3;
        req_d[1]  = 1'b1;
        we_d[1]   = 1'b1;
        addr_d[1] = 16'h0009;
        wd_d[1]   = 16'h5555;
        tick();
        req_d[1] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("abort_mwe", 32'(if3.mwe), 32'd0);
        check("abort_ready", 32'(if3.cpu_ready), 32'd0);
        check("abort_mra", 32'(if3.mra), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b1;
        repeat (6) tick();
        check("abort_mwe_never", 32'(mwes3 - m3), 32'd0);
        check("abort_no_done", 32'(dones3 - d3), 32'd0);
        check("abort_mem9", 32'(mem3[9]), 32'hA509);
        check("abort_ready_after", 32'(if3.cpu_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
